pipelined_control_unit: RTL and testbench
=========================================

Name: pipelined_control_unit

Overview:
- Registered successor to the combinational decode/control block of the pipelined core.
- Decodes the IF/ID instruction, including optional JAL/JALR/LUI, into control bits.
- Detects load-use hazards against its own ID/EX contents and drives the ID/EX control register with stall, bubble, flush and hold handling.
- Sits between the IF/ID register and the EX stage; also keeps a saturating illegal-instruction counter.

Parameters:
- CNT_W, 8: width of the illegal-instruction counter.
- ENABLE_JUMP, 1: 1 = decode JAL (1101111) and JALR (1100111); 0 = treat them as illegal.
- ENABLE_LUI, 1: 1 = decode LUI (0110111); 0 = treat it as illegal.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- instruction  input  32  instruction from the IF/ID register.
- id_valid  input  1  instruction is valid.
- flush  input  1  branch/jump redirect from EX; kill the ID/EX contents.
- hold  input  1  external pipeline freeze; ID/EX keeps its value.
- stall  output  1  combinational load-use stall to the PC and IF/ID.
- ex_valid  output  1  ID/EX holds a real instruction.
- ex_branch  output  1  registered control bit.
- ex_jump  output  1  registered control bit.
- ex_mem_read  output  1  registered control bit.
- ex_mem_to_reg  output  1  registered control bit.
- ex_mem_write  output  1  registered control bit.
- ex_alu_src  output  1  registered control bit.
- ex_reg_write  output  1  registered control bit.
- ex_alu_op  output  2  00 add, 01 compare, 10 R-funct, 11 I-funct.
- ex_wb_sel  output  2  00 ALU/mem, 10 PC+4, 11 immediate.
- ex_rs1  output  5  registered instruction field.
- ex_rs2  output  5  registered instruction field.
- ex_rd  output  5  registered instruction field.
- ex_funct3  output  3  registered instruction field.
- ex_funct7_5  output  1  registered instruction[30].
- ex_illegal  output  1  ID/EX holds an undecodable instruction.
- illegal_count  output  CNT_W  saturating count of illegal instructions loaded into ID/EX.

Behaviour:
- Reset: rst_n low asynchronously clears every registered output and illegal_count to 0. stall then depends only on id_valid and instruction, because ex_mem_read is 0.
- Decode (combinational; bits not listed are 0):
  - R-type 0110011: reg_write, alu_op=10.
  - Load 0000011: mem_read, mem_to_reg, alu_src, reg_write, alu_op=00.
  - Store 0100011: mem_write, alu_src, alu_op=00.
  - Branch 1100011: branch, alu_op=01.
  - I-ALU 0010011: alu_src, reg_write, alu_op=11.
  - JAL: jump, reg_write, wb_sel=10.
  - JALR: jump, alu_src, reg_write, wb_sel=10.
  - LUI: alu_src, reg_write, wb_sel=11.
  - Any other opcode, or a disabled one: illegal=1, all controls 0.
- reg_write is forced 0 when rd==0.
- Source use:
  - uses_rs1 for R, load, store, branch, I-ALU, JALR.
  - uses_rs2 for R, store, branch.
- stall (combinational) = id_valid & ex_valid & ex_mem_read & ex_rd!=0 & ((uses_rs1 & rs1==ex_rd) | (uses_rs2 & rs2==ex_rd)).
- ID/EX update at each rising clk edge, in priority order:
  1. flush: bubble.
  2. hold: keep all values.
  3. stall: bubble.
  4. id_valid: load decoded fields, ex_valid=1; illegal instructions load with ex_valid=1 and ex_illegal=1.
  5. Otherwise: bubble.
- Bubble: ex_valid, ex_illegal and all control bits 0; ex_alu_op and ex_wb_sel 00; field outputs 0.
- flush together with stall: flush wins, so a bubble is loaded. stall is still driven from the current inputs.
- hold together with stall: ID/EX is held. stall stays asserted, so IF/ID is also frozen.
- illegal_count: +1 only on a cycle that loads an illegal instruction (priority case 4). Saturates at 2^CNT_W-1 and never wraps.
- Latency: decoded controls appear on ex_* one cycle after acceptance.

Test Plan:
- Reset mid-stream: assert rst_n=0 asynchronously between edges with ex_valid=1 -> all ex_* outputs and illegal_count read 0 immediately, before the next edge.
- Load-use: load x5 (0x0002B283) is loaded into ID/EX, then add x6,x5,x7 is presented in ID -> stall=1 for exactly one cycle, a bubble follows (ex_valid=0), and the add enters next cycle with ex_alu_op=10, ex_reg_write=1.
- No false stall: load x0, then add x6,x0,x7 -> stall=0. Load x5, then lui x5 -> stall=0 because LUI does not use rs1/rs2.
- Flush versus hold: flush=1 and hold=1 together with a valid add -> ex_valid=0 next cycle. hold=1 alone for 3 cycles -> ex_* outputs remain unchanged.
- Jump enable: JAL x1 with ENABLE_JUMP=1 -> ex_jump=1, ex_wb_sel=10, ex_reg_write=1. Same instruction with ENABLE_JUMP=0 -> ex_illegal=1, all controls 0, illegal_count increments by 1.
- Counter saturation: CNT_W=2, present 5 illegal opcodes (0x0000007F) -> illegal_count ends at 3. Illegal instructions arriving under flush or stall do not increment the count.

Source files
------------

// File: rtl/pipelined_control_unit.sv
// Registered decode/control stage between IF/ID and EX: decodes the instruction,
// detects load-use hazards against ID/EX, and manages flush/hold/stall bubbles.
module pipelined_control_unit #(
    parameter int unsigned CNT_W       = 8,
    parameter bit          ENABLE_JUMP = 1'b1,
    parameter bit          ENABLE_LUI  = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instruction,
    input  logic             id_valid,
    input  logic             flush,
    input  logic             hold,
    output logic             stall,
    output logic             ex_valid,
    output logic             ex_branch,
    output logic             ex_jump,
    output logic             ex_mem_read,
    output logic             ex_mem_to_reg,
    output logic             ex_mem_write,
    output logic             ex_alu_src,
    output logic             ex_reg_write,
    output logic [1:0]       ex_alu_op,
    output logic [1:0]       ex_wb_sel,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic [2:0]       ex_funct3,
    output logic             ex_funct7_5,
    output logic             ex_illegal,
    output logic [CNT_W-1:0] illegal_count
);

    typedef enum logic [6:0] {
        OP_R      = 7'b0110011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_BRANCH = 7'b1100011,
        OP_IALU   = 7'b0010011,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_LUI    = 7'b0110111
    } opcode_e;

    typedef struct packed {
        logic       valid;
        logic       illegal;
        logic       branch;
        logic       jump;
        logic       mem_read;
        logic       mem_to_reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic [1:0] alu_op;
        logic [1:0] wb_sel;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic [2:0] funct3;
        logic       funct7_5;
    } idex_t;

    localparam idex_t BUBBLE = '0;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    idex_t      dec;
    idex_t      ex_q;
    logic       uses_rs1;
    logic       uses_rs2;
    logic       unused_imm_bits;

    assign rs1 = instruction[19:15];
    assign rs2 = instruction[24:20];
    assign rd  = instruction[11:7];

    // Immediate bits are consumed by the datapath, not by control.
    assign unused_imm_bits = ^{instruction[31], instruction[29:25]};

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        dec          = BUBBLE;
        uses_rs1     = 1'b0;
        uses_rs2     = 1'b0;
        dec.valid    = 1'b1;
        dec.rs1      = rs1;
        dec.rs2      = rs2;
        dec.rd       = rd;
        dec.funct3   = instruction[14:12];
        dec.funct7_5 = instruction[30];

        case (opcode_e'(instruction[6:0]))
            OP_R: begin
                dec.reg_write = 1'b1;
                dec.alu_op    = 2'b10;
                uses_rs1      = 1'b1;
                uses_rs2      = 1'b1;
            end
            OP_LOAD: begin
                dec.mem_read   = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.alu_src    = 1'b1;
                dec.reg_write  = 1'b1;
                uses_rs1       = 1'b1;
            end
            OP_STORE: begin
                dec.mem_write = 1'b1;
                dec.alu_src   = 1'b1;
                uses_rs1      = 1'b1;
                uses_rs2      = 1'b1;
            end
            OP_BRANCH: begin
                dec.branch = 1'b1;
                dec.alu_op = 2'b01;
                uses_rs1   = 1'b1;
                uses_rs2   = 1'b1;
            end
            OP_IALU: begin
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                dec.alu_op    = 2'b11;
                uses_rs1      = 1'b1;
            end
            OP_JAL: begin
                if (ENABLE_JUMP) begin
                    dec.jump      = 1'b1;
                    dec.reg_write = 1'b1;
                    dec.wb_sel    = 2'b10;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            OP_JALR: begin
                if (ENABLE_JUMP) begin
                    dec.jump      = 1'b1;
                    dec.alu_src   = 1'b1;
                    dec.reg_write = 1'b1;
                    dec.wb_sel    = 2'b10;
                    uses_rs1      = 1'b1;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            OP_LUI: begin
                if (ENABLE_LUI) begin
                    dec.alu_src   = 1'b1;
                    dec.reg_write = 1'b1;
                    dec.wb_sel    = 2'b11;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            default: dec.illegal = 1'b1;
        endcase

        // x0 is hardwired; never let a write to it reach the register file.
        if (rd == 5'd0) begin
            dec.reg_write = 1'b0;
        end
    end

    assign stall = id_valid & ex_q.valid & ex_q.mem_read & (ex_q.rd != 5'd0)
                 & ((uses_rs1 & (rs1 == ex_q.rd)) | (uses_rs2 & (rs2 == ex_q.rd)));

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            ex_q          <= BUBBLE;
            illegal_count <= '0;
        end else if (flush) begin
            ex_q <= BUBBLE;
        end else if (hold) begin
            ex_q <= ex_q;
        end else if (stall) begin
            ex_q <= BUBBLE;
        end else if (id_valid) begin
            ex_q <= dec;
            if (dec.illegal && (illegal_count != CNT_MAX)) begin
                illegal_count <= illegal_count + CNT_W'(1);
            end
        end else begin
            ex_q <= BUBBLE;
        end
    end

    assign ex_valid      = ex_q.valid;
    assign ex_illegal    = ex_q.illegal;
    assign ex_branch     = ex_q.branch;
    assign ex_jump       = ex_q.jump;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_mem_to_reg = ex_q.mem_to_reg;
    assign ex_mem_write  = ex_q.mem_write;
    assign ex_alu_src    = ex_q.alu_src;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_alu_op     = ex_q.alu_op;
    assign ex_wb_sel     = ex_q.wb_sel;
    assign ex_rs1        = ex_q.rs1;
    assign ex_rs2        = ex_q.rs2;
    assign ex_rd         = ex_q.rd;
    assign ex_funct3     = ex_q.funct3;
    assign ex_funct7_5   = ex_q.funct7_5;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Bench for pipelined_control_unit: a default instance and a reduced one
// (jumps/LUI disabled, 2-bit counter) share stimulus; a scoreboard checks both.
module tb_pipelined_control_unit;

    typedef struct packed {
        logic       valid;
        logic       illegal;
        logic       branch;
        logic       jump;
        logic       mem_read;
        logic       mem_to_reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic [1:0] alu_op;
        logic [1:0] wb_sel;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic [2:0] funct3;
        logic       funct7_5;
    } ex_t;

    typedef struct {
        ex_t        a;
        ex_t        b;
        logic [7:0] ca;
        logic [1:0] cb;
    } sb_t;

    localparam logic [31:0] I_LW5    = 32'h0002B283;
    localparam logic [31:0] I_LW0    = 32'h0002B003;
    localparam logic [31:0] I_ADD    = 32'h00728333;
    localparam logic [31:0] I_ADD_X0 = 32'h00700333;
    localparam logic [31:0] I_LUI5   = 32'h123452B7;
    localparam logic [31:0] I_JAL1   = 32'h008000EF;
    localparam logic [31:0] I_JALR   = 32'h000100E7;
    localparam logic [31:0] I_ILL    = 32'h0000007F;
    localparam logic [31:0] I_SW     = 32'h0072A023;
    localparam logic [31:0] I_BEQ    = 32'h00628063;
    localparam logic [31:0] I_ADDI   = 32'h00128293;
    localparam logic [31:0] I_SUB    = 32'h40530333;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instruction;
    logic        id_valid, flush, hold;

    logic       stall_a, ex_valid_a, ex_branch_a, ex_jump_a, ex_mem_read_a, ex_mem_to_reg_a;
    logic       ex_mem_write_a, ex_alu_src_a, ex_reg_write_a, ex_funct7_5_a, ex_illegal_a;
    logic [1:0] ex_alu_op_a, ex_wb_sel_a;
    logic [4:0] ex_rs1_a, ex_rs2_a, ex_rd_a;
    logic [2:0] ex_funct3_a;
    logic [7:0] illegal_count_a;

    logic       stall_b, ex_valid_b, ex_branch_b, ex_jump_b, ex_mem_read_b, ex_mem_to_reg_b;
    logic       ex_mem_write_b, ex_alu_src_b, ex_reg_write_b, ex_funct7_5_b, ex_illegal_b;
    logic [1:0] ex_alu_op_b, ex_wb_sel_b;
    logic [4:0] ex_rs1_b, ex_rs2_b, ex_rd_b;
    logic [2:0] ex_funct3_b;
    logic [1:0] illegal_count_b;

    ex_t obs_a, obs_b;
    ex_t st_a, st_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;
    logic last_stall_a, last_stall_b;
    sb_t sb_q[$];
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign obs_a = {ex_valid_a, ex_illegal_a, ex_branch_a, ex_jump_a, ex_mem_read_a, ex_mem_to_reg_a,
                    ex_mem_write_a, ex_alu_src_a, ex_reg_write_a, ex_alu_op_a, ex_wb_sel_a,
                    ex_rs1_a, ex_rs2_a, ex_rd_a, ex_funct3_a, ex_funct7_5_a};
    assign obs_b = {ex_valid_b, ex_illegal_b, ex_branch_b, ex_jump_b, ex_mem_read_b, ex_mem_to_reg_b,
                    ex_mem_write_b, ex_alu_src_b, ex_reg_write_b, ex_alu_op_b, ex_wb_sel_b,
                    ex_rs1_b, ex_rs2_b, ex_rd_b, ex_funct3_b, ex_funct7_5_b};

    pipelined_control_unit dut_a (
        .clk(clk), .rst_n(rst_n), .instruction(instruction), .id_valid(id_valid),
        .flush(flush), .hold(hold), .stall(stall_a), .ex_valid(ex_valid_a),
        .ex_branch(ex_branch_a), .ex_jump(ex_jump_a), .ex_mem_read(ex_mem_read_a),
        .ex_mem_to_reg(ex_mem_to_reg_a), .ex_mem_write(ex_mem_write_a), .ex_alu_src(ex_alu_src_a),
        .ex_reg_write(ex_reg_write_a), .ex_alu_op(ex_alu_op_a), .ex_wb_sel(ex_wb_sel_a),
        .ex_rs1(ex_rs1_a), .ex_rs2(ex_rs2_a), .ex_rd(ex_rd_a), .ex_funct3(ex_funct3_a),
        .ex_funct7_5(ex_funct7_5_a), .ex_illegal(ex_illegal_a), .illegal_count(illegal_count_a)
    );

    pipelined_control_unit #(.CNT_W(2), .ENABLE_JUMP(1'b0), .ENABLE_LUI(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .instruction(instruction), .id_valid(id_valid),
        .flush(flush), .hold(hold), .stall(stall_b), .ex_valid(ex_valid_b),
        .ex_branch(ex_branch_b), .ex_jump(ex_jump_b), .ex_mem_read(ex_mem_read_b),
        .ex_mem_to_reg(ex_mem_to_reg_b), .ex_mem_write(ex_mem_write_b), .ex_alu_src(ex_alu_src_b),
        .ex_reg_write(ex_reg_write_b), .ex_alu_op(ex_alu_op_b), .ex_wb_sel(ex_wb_sel_b),
        .ex_rs1(ex_rs1_b), .ex_rs2(ex_rs2_b), .ex_rd(ex_rd_b), .ex_funct3(ex_funct3_b),
        .ex_funct7_5(ex_funct7_5_b), .ex_illegal(ex_illegal_b), .illegal_count(illegal_count_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic ex_t model_decode(input logic [31:0] ins, input bit en_j, input bit en_l,
                                         output bit u1, output bit u2);
        ex_t d = '0;
        u1 = 1'b0;
        u2 = 1'b0;
        d.valid    = 1'b1;
        d.rs1      = ins[19:15];
        d.rs2      = ins[24:20];
        d.rd       = ins[11:7];
        d.funct3   = ins[14:12];
        d.funct7_5 = ins[30];
        case (ins[6:0])
            7'b0110011: begin d.reg_write = 1; d.alu_op = 2'b10; u1 = 1; u2 = 1; end
            7'b0000011: begin d.mem_read = 1; d.mem_to_reg = 1; d.alu_src = 1; d.reg_write = 1; u1 = 1; end
            7'b0100011: begin d.mem_write = 1; d.alu_src = 1; u1 = 1; u2 = 1; end
            7'b1100011: begin d.branch = 1; d.alu_op = 2'b01; u1 = 1; u2 = 1; end
            7'b0010011: begin d.alu_src = 1; d.reg_write = 1; d.alu_op = 2'b11; u1 = 1; end
            7'b1101111: if (en_j) begin d.jump = 1; d.reg_write = 1; d.wb_sel = 2'b10; end
                        else d.illegal = 1;
            7'b1100111: if (en_j) begin d.jump = 1; d.alu_src = 1; d.reg_write = 1; d.wb_sel = 2'b10; u1 = 1; end
                        else d.illegal = 1;
            7'b0110111: if (en_l) begin d.alu_src = 1; d.reg_write = 1; d.wb_sel = 2'b11; end
                        else d.illegal = 1;
            default:    d.illegal = 1;
        endcase
        if (d.rd == 5'd0) d.reg_write = 1'b0;
        return d;
    endfunction

    task automatic model_step(input ex_t cur, input logic [31:0] ins, input bit v, input bit f,
                              input bit h, input bit en_j, input bit en_l,
                              output ex_t nxt, output bit stl, output bit inc);
        bit u1, u2;
        ex_t d;
        d   = model_decode(ins, en_j, en_l, u1, u2);
        stl = v && cur.valid && cur.mem_read && (cur.rd != 5'd0) &&
              ((u1 && ins[19:15] == cur.rd) || (u2 && ins[24:20] == cur.rd));
        inc = 1'b0;
        if (f)        nxt = '0;
        else if (h)   nxt = cur;
        else if (stl) nxt = '0;
        else if (v) begin
            nxt = d;
            inc = d.illegal;
        end else      nxt = '0;
    endtask

    // One cycle: drive at negedge, check stall, push expectation, compare after the edge.
    task automatic step(input logic [31:0] ins, input bit v, input bit f, input bit h);
        ex_t na, nb;
        bit sa, sb, ia, ib;
        sb_t e;
        @(negedge clk);
        instruction = ins;
        id_valid    = v;
        flush       = f;
        hold        = h;
        #1;
        model_step(st_a, ins, v, f, h, 1'b1, 1'b1, na, sa, ia);
        model_step(st_b, ins, v, f, h, 1'b0, 1'b0, nb, sb, ib);
        check("stall_a", stall_a, sa);
        check("stall_b", stall_b, sb);
        last_stall_a = stall_a;
        last_stall_b = stall_b;
        if (ia && cnt_a != 8'hFF) cnt_a = cnt_a + 8'd1;
        if (ib && cnt_b != 2'b11) cnt_b = cnt_b + 2'd1;
        st_a = na;
        st_b = nb;
        e.a  = na;
        e.b  = nb;
        e.ca = cnt_a;
        e.cb = cnt_b;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check("ex_a", obs_a, e.a);
        check("ex_b", obs_b, e.b);
        check("cnt_a", illegal_count_a, e.ca);
        check("cnt_b", illegal_count_b, e.cb);
    endtask

    task automatic model_reset();
        st_a  = '0;
        st_b  = '0;
        cnt_a = '0;
        cnt_b = '0;
    endtask

    logic [31:0] rnd_tbl [12];

    initial begin
        rnd_tbl = '{I_LW5, I_LW0, I_ADD, I_ADD_X0, I_LUI5, I_JAL1,
                    I_JALR, I_ILL, I_SW, I_BEQ, I_ADDI, I_SUB};
        rst_n = 1'b0;
        instruction = '0;
        id_valid = 1'b0;
        flush = 1'b0;
        hold = 1'b0;
        model_reset();
        #2;
        check("reset_ex_a", obs_a, '0);
        check("reset_ex_b", obs_b, '0);
        check("reset_cnt_a", illegal_count_a, 0);
        check("reset_cnt_b", illegal_count_b, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Load-use: one stall, one bubble, then the add issues.
        step(I_LW5, 1, 0, 0);
        step(I_ADD, 1, 0, 0);
        check("lu_stall", last_stall_a, 1);
        check("lu_bubble", ex_valid_a, 0);
        step(I_ADD, 1, 0, 0);
        check("lu_stall_clear", last_stall_a, 0);
        check("lu_add_op", ex_alu_op_a, 2'b10);
        check("lu_add_rw", ex_reg_write_a, 1);

        // No false stalls.
        step(I_LW0, 1, 0, 0);
        step(I_ADD_X0, 1, 0, 0);
        check("x0_no_stall", last_stall_a, 0);
        step(I_LW5, 1, 0, 0);
        step(I_LUI5, 1, 0, 0);
        check("lui_no_stall_a", last_stall_a, 0);
        check("lui_no_stall_b", last_stall_b, 0);

        // Flush beats hold; hold freezes ID/EX.
        step(I_ADD, 1, 1, 1);
        check("flush_hold_valid", ex_valid_a, 0);
        step(I_ADDI, 1, 0, 0);
        repeat (3) step(I_SW, 1, 0, 1);
        check("hold_valid", ex_valid_a, 1);
        check("hold_rd", ex_rd_a, 5'd5);
        check("hold_alu_op", ex_alu_op_a, 2'b11);

        // Asynchronous reset between edges.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_ex_a", obs_a, '0);
        check("midrst_ex_b", obs_b, '0);
        check("midrst_cnt_a", illegal_count_a, 0);
        check("midrst_cnt_b", illegal_count_b, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Jump enable versus disable.
        step(I_JAL1, 1, 0, 0);
        check("jal_jump_a", ex_jump_a, 1);
        check("jal_wb_a", ex_wb_sel_a, 2'b10);
        check("jal_rw_a", ex_reg_write_a, 1);
        check("jal_illegal_b", ex_illegal_b, 1);
        check("jal_jump_b", ex_jump_b, 0);
        check("jal_rw_b", ex_reg_write_b, 0);
        check("jal_cnt_b", illegal_count_b, 1);

        // Illegal under flush or hold does not count; then saturate.
        step(I_ILL, 1, 1, 0);
        step(I_ILL, 1, 0, 1);
        check("ill_flush_hold_cnt_b", illegal_count_b, 1);
        check("ill_flush_hold_cnt_a", illegal_count_a, 0);
        repeat (5) step(I_ILL, 1, 0, 0);
        check("sat_cnt_b", illegal_count_b, 3);
        check("sat_cnt_a", illegal_count_a, 5);

        // Random mix against the model.
        for (int i = 0; i < 80; i++) begin
            step(rnd_tbl[$urandom_range(0, 11)], $urandom_range(0, 3) != 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0);
        end

        check("sb_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
